// File: rtl/display_driver_pkg.sv
// Shared types, segment constants and arithmetic helpers for the
// multiplexed 4-digit decimal display driver.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Unsigned magnitude; 0x80 in signed mode stays 0x80 and reads as 128.
    function automatic logic [7:0] magnitude(input logic [7:0] v, input logic sm);
        if (sm && v[7]) begin
            return ~v + 8'd1;
        end else begin
            return v;
        end
    endfunction

    // One double-dabble step on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end else begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/display_driver_seg7_decode.sv
// Combinational BCD digit to active-high seven-segment pattern, with a
// blank override used for leading-zero suppression.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Digit lookup; out-of-range codes show blank.
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_driver.sv
// Captures an 8-bit value, converts it to sign + 3 BCD digits over 9 cycles
// and drives a time-multiplexed 4-digit seven-segment display.
module display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       oi,
    input  logic [7:0] data_i,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] digit_en,
    output logic       busy
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_e      state_q;
    logic [2:0]  step_q;
    logic [19:0] conv_q;
    logic        conv_sign_q;
    logic        pend_valid_q;
    logic [7:0]  pend_data_q;
    logic        pend_signed_q;
    logic        busy_q;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic        sign_q;

    logic [3:0]  hund_s, tens_s, ones_s;
    logic        sign_s;
    logic [7:0]  src_data_s;
    logic        src_signed_s;
    logic [19:0] start_conv_s;
    logic        start_neg_s;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  digit_en_q, digit_en_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  dec_digit_s;
    logic        dec_blank_s;
    logic [6:0]  dec_seg_s;

    // Displayed value as it will be after this edge, so seg follows an update at once.
    always_comb begin
        if (state_q == ST_UPDATE) begin
            hund_s = conv_q[19:16];
            tens_s = conv_q[15:12];
            ones_s = conv_q[11:8];
            sign_s = conv_sign_q;
        end else begin
            hund_s = hund_q;
            tens_s = tens_q;
            ones_s = ones_q;
            sign_s = sign_q;
        end
    end

    // A fresh strobe always beats the pending slot (last write wins).
    always_comb begin
        if (oi) begin
            src_data_s   = data_i;
            src_signed_s = signed_mode;
        end else begin
            src_data_s   = pend_data_q;
            src_signed_s = pend_signed_q;
        end
        start_conv_s = {12'd0, magnitude(src_data_s, src_signed_s)};
        start_neg_s  = src_signed_s & src_data_s[7];
    end

    // Conversion sequencer, pending slot and displayed-value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= 3'd0;
            conv_q        <= 20'd0;
            conv_sign_q   <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= 8'd0;
            pend_signed_q <= 1'b0;
            busy_q        <= 1'b0;
            hund_q        <= 4'd0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            sign_q        <= 1'b0;
        end else begin
            hund_q <= hund_s;
            tens_q <= tens_s;
            ones_q <= ones_s;
            sign_q <= sign_s;
            case (state_q)
                ST_IDLE: begin
                    if (oi) begin
                        state_q     <= ST_CONVERT;
                        step_q      <= 3'd0;
                        conv_q      <= start_conv_s;
                        conv_sign_q <= start_neg_s;
                        busy_q      <= 1'b1;
                    end else begin
                        busy_q      <= pend_valid_q;
                    end
                end
                ST_CONVERT: begin
                    conv_q <= dd_step(conv_q);
                    step_q <= step_q + 3'd1;
                    busy_q <= 1'b1;
                    if (oi) begin
                        pend_valid_q  <= 1'b1;
                        pend_data_q   <= data_i;
                        pend_signed_q <= signed_mode;
                    end else begin
                        pend_valid_q  <= pend_valid_q;
                    end
                    if (step_q == 3'd7) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        state_q <= ST_CONVERT;
                    end
                end
                ST_UPDATE: begin
                    if (oi || pend_valid_q) begin
                        state_q      <= ST_CONVERT;
                        step_q       <= 3'd0;
                        conv_q       <= start_conv_s;
                        conv_sign_q  <= start_neg_s;
                        pend_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    pend_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Refresh timing and selection of the digit to be shown after this edge.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
        digit_en_d = 4'b0001 << idx_d;
        case (idx_d)
            2'd0: begin
                dec_digit_s = ones_s;
                dec_blank_s = 1'b0;
            end
            2'd1: begin
                dec_digit_s = tens_s;
                dec_blank_s = (hund_s == 4'd0) && (tens_s == 4'd0);
            end
            2'd2: begin
                dec_digit_s = hund_s;
                dec_blank_s = (hund_s == 4'd0);
            end
            default: begin
                dec_digit_s = 4'd0;
                dec_blank_s = 1'b1;
            end
        endcase
        if (idx_d == 2'd3) begin
            seg_d = sign_s ? SEG_MINUS : SEG_BLANK;
        end else begin
            seg_d = dec_seg_s;
        end
    end

    seg7_decode u_seg7_decode (
        .digit_i (dec_digit_s),
        .blank_i (dec_blank_s),
        .seg_o   (dec_seg_s)
    );

    // Refresh counter and the registered digit select / segment outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            digit_en_q <= 4'b0001;
            seg_q      <= SEG_0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench: directed scenarios then random strobes and resets,
// compared every cycle against a cycle-level model of the display.
module tb_display_driver;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       oi;
    logic [7:0] data_i;
    logic       signed_mode;
    logic [6:0] seg;
    logic [3:0] digit_en;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // model state
    int         k;
    int         edge_n;
    bit         act;
    int         end_e;
    logic [7:0] cur_v;
    bit         cur_s;
    bit         pend;
    logic [7:0] pend_v;
    bit         pend_s;
    logic [7:0] disp_v;
    bit         disp_s;

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    display_driver #(.REFRESH_DIV(RDIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .oi          (oi),
        .data_i      (data_i),
        .signed_mode (signed_mode),
        .seg         (seg),
        .digit_en    (digit_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int idx);
        int m, h, t, o;
        bit neg;
        neg = disp_s && disp_v[7];
        m   = neg ? (256 - int'(disp_v)) : int'(disp_v);
        h   = m / 100;
        t   = (m / 10) % 10;
        o   = m % 10;
        case (idx)
            0:       return segtab[o];
            1:       return (h == 0 && t == 0) ? 7'h00 : segtab[t];
            2:       return (h == 0) ? 7'h00 : segtab[h];
            default: return neg ? 7'h40 : 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int idx;
        idx = (k / RDIV) % 4;
        chk("digit_en", {4'b0, digit_en}, 8'(1 << idx));
        chk("seg",      {1'b0, seg},      {1'b0, exp_seg(idx)});
        chk("busy",     {7'b0, busy},     {7'b0, (act || pend)});
    endtask

    task automatic model_reset();
        k = 0; edge_n = 0; act = 0; end_e = 0; pend = 0;
        disp_v = 8'd0; disp_s = 0;
    endtask

    task automatic model_start(input logic [7:0] d, input bit s);
        cur_v = d; cur_s = s; end_e = edge_n + 9; act = 1;
    endtask

    task automatic model_edge(input bit o, input logic [7:0] d, input bit s);
        edge_n++;
        k++;
        if (act && edge_n == end_e) begin
            disp_v = cur_v;
            disp_s = cur_s;
            if (o) begin
                model_start(d, s);
                pend = 0;
            end else if (pend) begin
                model_start(pend_v, pend_s);
                pend = 0;
            end else begin
                act = 0;
            end
        end else if (act) begin
            if (o) begin
                pend = 1; pend_v = d; pend_s = s;
            end
        end else if (o) begin
            model_start(d, s);
        end
    endtask

    task automatic tick(input bit o, input logic [7:0] d, input bit s);
        oi = o; data_i = d; signed_mode = s;
        @(posedge clk);
        model_edge(o, d, s);
        @(negedge clk);
        check_all();
        oi = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; oi = 1'b0; data_i = 8'h00; signed_mode = 1'b0;
        #2;
        do_reset();

        idle(20);
        tick(1'b1, 8'hFF, 1'b0); idle(14);
        tick(1'b1, 8'h80, 1'b1); idle(14);
        tick(1'b1, 8'h07, 1'b0); idle(14);
        tick(1'b1, 8'hFF, 1'b1); idle(14);
        tick(1'b1, 8'h64, 1'b0); idle(14);

        // 16 then 42 queued behind it
        tick(1'b1, 8'h10, 1'b0); tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h2A, 1'b0); idle(22);

        // last write wins in the pending slot
        tick(1'b1, 8'h05, 1'b0); tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0); idle(24);

        // reset in the middle of converting 99
        tick(1'b1, 8'h63, 1'b0); idle(3);
        do_reset();
        idle(16);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                tick(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else begin
                tick(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1024, meaning clock cycles each digit stays enabled (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port oi  input  1  output-register write strobe; a new value is accepted on each rising edge where oi=1.
REQ-005 SHALL have port data_i  input  8  value to display, sampled when oi=1.
REQ-006 SHALL have port signed_mode  input  1  sampled with data_i; 1 means data_i is two's complement.
REQ-007 SHALL have port seg  output  7  segment pattern, active-high; seg[0]=a through seg[6]=g.
REQ-008 SHALL have port digit_en  output  4  one-hot active-high digit select; bit 0 is ones, bit 3 is sign.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress or pending.

Function
REQ-010 SHALL implement states IDLE, CONVERT and UPDATE.
REQ-011 IDLE with oi=1 at edge N SHALL capture data_i and signed_mode, take the magnitude, clear the BCD accumulator and enter CONVERT.
REQ-012 Magnitude SHALL be data_i unsigned, or the two's-complement negation when signed_mode=1 and data_i[7]=1; 0x80 signed SHALL give magnitude 128 with the sign set.
REQ-013 CONVERT SHALL perform one shift-add-3 (double-dabble) step per cycle at edges N+1..N+8, with a 3-bit step counter, then go to UPDATE.
REQ-014 UPDATE at edge N+9 SHALL load the displayed hundreds, tens, ones and sign registers, then return to IDLE; fixed latency from oi to new display is 9 cycles.
REQ-015 oi=1 while in CONVERT or UPDATE SHALL overwrite a single pending slot (last write wins) without disturbing the current conversion.
REQ-016 UPDATE with the pending slot full SHALL load the pending value as at REQ-011 on the same edge and clear the slot; the second display update then lands 9 cycles later.
REQ-017 busy SHALL be 1 in CONVERT and UPDATE, and whenever the pending slot is full.
REQ-018 Digit contents: digit0 is the ones digit, always shown; digit1 is tens, blank when hundreds and tens are both 0; digit2 is hundreds, blank when 0; digit3 is minus (0x40) when the sign is set, else blank (0x00).
REQ-019 Segment codes 0-9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap the digit index SHALL advance 0,1,2,3,0.
REQ-021 digit_en SHALL equal 1<<index, and seg SHALL be the pattern of that digit, registered so both change on the same edge.
REQ-022 The refresh SHALL run independently of conversion state; a display update SHALL NOT reset the refresh counter or index.

Reset
REQ-023 rst=1 SHALL immediately force: IDLE, pending slot empty, busy=0, displayed value 0 unsigned, refresh counter 0, index 0, digit_en=0001, seg=0x3F.
REQ-024 rst asserted mid-conversion SHALL discard both the in-flight and pending values with no display update.

Structure
REQ-025 Package display_pkg SHALL hold the state enumeration, the ten digit segment constants, and SEG_BLANK=0x00 and SEG_MINUS=0x40.
REQ-026 Combinational sub-module seg7_decode SHALL map a 4-bit digit plus a blank flag to a 7-bit pattern; display_driver SHALL instantiate it once for the selected digit.

Verification (REFRESH_DIV=4 in the bench)
REQ-027 Reset with no oi -> digit_en rotates 0001,0010,0100,1000 every 4 cycles; seg is 3F on digit0 and 00 on digits 1-3; busy=0.
REQ-028 oi with data_i=0xFF, signed_mode=0 -> busy=1 for 9 cycles; then digit2=5B, digit1=6D, digit0=6D, digit3=00.
REQ-029 oi with data_i=0x80, signed_mode=1 -> after 9 cycles digit3=40, digit2=06, digit1=5B, digit0=7F (-128).
REQ-030 oi with data_i=0x07, signed_mode=0 -> digit2=00, digit1=00, digit0=07 (leading-zero blanking).
REQ-031 oi 0x10 at edge N and oi 0x2A at N+2 -> display 16 from N+9, display 42 (digit1=66, digit0=5B, digit2=00) from N+18; busy falls after N+18.
REQ-032 oi 0x63 at edge N, rst at N+4 -> busy=0 and display 0 (seg 3F on digit0) immediately; 99 never appears.
